mult_operand_scheduler: RTL and testbench

- Schedules operand pairs into the multiplier.
- Two requesters (s0, s1) submit (op_a, op_b) pairs. The block round-robin arbitrates them into a pair of external 8-deep operand FIFOs (FIFO A, FIFO B), written in lockstep.
- A read FSM pops one pair, issues it to the field multiplier and waits for completion.
- On completion it reports which requester owned the result.
- Sits between the point-arithmetic sequencer's requesters and the multiplier core.

---
 rtl/mult_operand_scheduler.sv | 161 ++++++++++++++++
 tb/tb_mult_operand_scheduler.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_operand_scheduler.sv
// Purpose: round-robin two requesters into lockstep A/B operand FIFOs, then pop/load/issue pairs to the multiplier and tag each result with its owner.
// Latency: pair accepted at edge t -> FIFO pop in cycle t+1, mul_start from edge t+3; res_valid in the same cycle as mul_done.
// Backpressure: sN_ready drops when 8 pairs are buffered or either FIFO is full; the read side holds in BUSY until mul_done.
module mult_operand_scheduler #(
  parameter int DATA  = 512,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s0_valid,
  output logic            s0_ready,
  input  logic [DATA-1:0] s0_op_a,
  input  logic [DATA-1:0] s0_op_b,
  input  logic            s1_valid,
  output logic            s1_ready,
  input  logic [DATA-1:0] s1_op_a,
  input  logic [DATA-1:0] s1_op_b,
  output logic            fa_wr_en,
  output logic [DATA-1:0] fa_din,
  output logic            fa_rd_en,
  input  logic [DATA-1:0] fa_dout,
  input  logic            fa_full,
  input  logic            fa_empty,
  output logic            fb_wr_en,
  output logic [DATA-1:0] fb_din,
  output logic            fb_rd_en,
  input  logic [DATA-1:0] fb_dout,
  input  logic            fb_full,
  input  logic            fb_empty,
  output logic            mul_start,
  output logic [DATA-1:0] mul_op_a,
  output logic [DATA-1:0] mul_op_b,
  input  logic            mul_done,
  output logic            res_valid,
  output logic            res_src,
  output logic [3:0]      pairs,
  output logic            desync
);

  typedef enum logic [2:0] {IDLE, POP, LOAD, ISSUE, BUSY} state_t;

  state_t           state;
  logic [2:0]       wr_ptr;
  logic [2:0]       rd_ptr;
  logic [DEPTH-1:0] tag_ring;
  logic             rr_last;
  logic             cur_src;
  logic             rd_en_q;
  logic             start_q;
  logic             space;
  logic             grant;
  logic             wr_xfer;
  logic             do_pop;

  // Arbitration: a lone requester always wins, a tie goes to whoever did not win last.
  always_comb begin
    space = (pairs < 4'(DEPTH)) && !fa_full && !fb_full;
    grant = 1'b0;
    if (s0_valid && s1_valid) begin
      grant = !rr_last;
    end else begin
      grant = s1_valid;
    end
    s0_ready = space && !grant;
    s1_ready = space && grant;
    wr_xfer  = (s0_valid && s0_ready) || (s1_valid && s1_ready);
    do_pop   = (state == POP);
  end

  assign fa_wr_en  = wr_xfer;
  assign fb_wr_en  = wr_xfer;
  assign fa_din    = grant ? s1_op_a : s0_op_a;
  assign fb_din    = grant ? s1_op_b : s0_op_b;
  assign fa_rd_en  = rd_en_q;
  assign fb_rd_en  = rd_en_q;
  assign mul_start = start_q;
  assign res_valid = (state == BUSY) && mul_done;
  assign res_src   = cur_src;

  // Tag ring write side: owner id follows each pair into the FIFOs, pointer wraps with them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      tag_ring <= '0;
      rr_last  <= 1'b1;
    end else if (wr_xfer) begin
      tag_ring[wr_ptr] <= grant;
      wr_ptr           <= wr_ptr + 3'd1;
      rr_last          <= grant;
    end
  end

  // Buffered-pair count: up on accept, down on pop, unchanged when both coincide.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pairs <= '0;
    end else begin
      case ({wr_xfer, do_pop})
        2'b10:   pairs <= pairs + 4'd1;
        2'b01:   pairs <= pairs - 4'd1;
        default: pairs <= pairs;
      endcase
    end
  end

  // Read FSM: pop one pair, load it into the operand registers, pulse start, wait for done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rd_en_q  <= 1'b0;
      start_q  <= 1'b0;
      rd_ptr   <= '0;
      cur_src  <= 1'b0;
      mul_op_a <= '0;
      mul_op_b <= '0;
    end else begin
      rd_en_q <= 1'b0;
      start_q <= 1'b0;
      case (state)
        IDLE: begin
          if ((pairs != 4'd0) && !fa_empty && !fb_empty) begin
            state   <= POP;
            rd_en_q <= 1'b1;
          end
        end
        POP: begin
          state <= LOAD;
        end
        LOAD: begin
          mul_op_a <= fa_dout;
          mul_op_b <= fb_dout;
          cur_src  <= tag_ring[rd_ptr];
          rd_ptr   <= rd_ptr + 3'd1;
          start_q  <= 1'b1;
          state    <= ISSUE;
        end
        ISSUE: begin
          state <= BUSY;
        end
        BUSY: begin
          if (mul_done) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Sticky flag: the FIFOs are not reset, so stale entries show up as count/flag disagreement.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      desync <= 1'b0;
    end else if (((pairs == 4'd0) != fa_empty) || ((pairs == 4'd0) != fb_empty)) begin
      desync <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mult_operand_scheduler.sv
// Bench for mult_operand_scheduler: FIFO and multiplier models, a pair-order scoreboard,
// a table of single-op vectors and directed multi-cycle sequences.
module tb_mult_operand_scheduler;
  localparam int DATA = 512;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            s0_valid, s1_valid;
  logic            s0_ready, s1_ready;
  logic [DATA-1:0] s0_op_a, s0_op_b, s1_op_a, s1_op_b;
  logic            fa_wr_en, fb_wr_en, fa_rd_en, fb_rd_en;
  logic [DATA-1:0] fa_din, fb_din;
  logic [DATA-1:0] fa_dout = '0;
  logic [DATA-1:0] fb_dout = '0;
  logic            fa_full, fa_empty, fb_full, fb_empty;
  logic            mul_start;
  logic [DATA-1:0] mul_op_a, mul_op_b;
  logic            mul_done = 1'b0;
  logic            res_valid, res_src;
  logic [3:0]      pairs;
  logic            desync;

  always #5 clk = ~clk;

  mult_operand_scheduler #(.DATA(DATA), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_op_a(s0_op_a), .s0_op_b(s0_op_b),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_op_a(s1_op_a), .s1_op_b(s1_op_b),
    .fa_wr_en(fa_wr_en), .fa_din(fa_din), .fa_rd_en(fa_rd_en), .fa_dout(fa_dout),
    .fa_full(fa_full), .fa_empty(fa_empty),
    .fb_wr_en(fb_wr_en), .fb_din(fb_din), .fb_rd_en(fb_rd_en), .fb_dout(fb_dout),
    .fb_full(fb_full), .fb_empty(fb_empty),
    .mul_start(mul_start), .mul_op_a(mul_op_a), .mul_op_b(mul_op_b), .mul_done(mul_done),
    .res_valid(res_valid), .res_src(res_src), .pairs(pairs), .desync(desync)
  );

  // ---------------- external FIFO models (no reset; flush only on request) ----------------
  logic [DATA-1:0] fa_mem [8];
  logic [DATA-1:0] fb_mem [8];
  int              fa_cnt = 0, fb_cnt = 0;
  logic [2:0]      fa_wp = '0, fa_rp = '0, fb_wp = '0, fb_rp = '0;
  logic            fifo_flush = 1'b0;

  assign fa_full  = (fa_cnt == 8);
  assign fa_empty = (fa_cnt == 0);
  assign fb_full  = (fb_cnt == 8);
  assign fb_empty = (fb_cnt == 0);

  always @(posedge clk) begin
    if (fifo_flush) begin
      fa_cnt <= 0; fa_wp <= '0; fa_rp <= '0;
      fb_cnt <= 0; fb_wp <= '0; fb_rp <= '0;
    end else begin
      if (fa_wr_en && !fa_full) begin fa_mem[fa_wp] <= fa_din; fa_wp <= fa_wp + 3'd1; end
      if (fa_rd_en && !fa_empty) begin fa_dout <= fa_mem[fa_rp]; fa_rp <= fa_rp + 3'd1; end
      fa_cnt <= fa_cnt + ((fa_wr_en && !fa_full) ? 1 : 0) - ((fa_rd_en && !fa_empty) ? 1 : 0);
      if (fb_wr_en && !fb_full) begin fb_mem[fb_wp] <= fb_din; fb_wp <= fb_wp + 3'd1; end
      if (fb_rd_en && !fb_empty) begin fb_dout <= fb_mem[fb_rp]; fb_rp <= fb_rp + 3'd1; end
      fb_cnt <= fb_cnt + ((fb_wr_en && !fb_full) ? 1 : 0) - ((fb_rd_en && !fb_empty) ? 1 : 0);
    end
  end

  // ---------------- multiplier model: done mul_lat cycles after start, held while mul_hold ----------------
  int   mul_lat  = 2;
  logic mul_hold = 1'b0;
  logic mul_pend = 1'b0;
  int   mul_cnt  = 0;

  always @(posedge clk) begin
    mul_done <= 1'b0;
    if (mul_start) begin
      mul_pend <= 1'b1;
      mul_cnt  <= mul_lat - 1;
    end else if (mul_pend) begin
      if (mul_cnt > 1) mul_cnt <= mul_cnt - 1;
      else if (!mul_hold) begin
        mul_done <= 1'b1;
        mul_pend <= 1'b0;
      end
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [DATA-1:0] act, input logic [DATA-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm, input string why);
    checks++;
    failures++;
    $display("FAIL %s: got %s", nm, why);
  endtask

  // Reference model: accepted pairs queue in order; each start consumes the oldest;
  // each result belongs to the oldest issued op. Round-robin: tie goes to the non-last winner.
  typedef struct {
    bit              src;
    logic [DATA-1:0] a;
    logic [DATA-1:0] b;
  } pair_t;

  pair_t ref_q[$];
  bit    infl_q[$];
  bit    ref_rr = 1'b1;
  int    n_acc = 0, n_start = 0, n_res = 0;

  always @(negedge clk) begin : mon
    bit    x0, x1, xs;
    pair_t p;
    if (!rst_n) begin
      ref_q.delete();
      infl_q.delete();
      ref_rr = 1'b1;
    end else begin
      x0 = s0_valid && s0_ready;
      x1 = s1_valid && s1_ready;
      if (x0 || x1 || fa_wr_en || fb_wr_en) begin
        chk("single_grant", {{(DATA-1){1'b0}}, x0 && x1}, '0);
        chk("fa_wr_en", {{(DATA-1){1'b0}}, fa_wr_en}, {{(DATA-1){1'b0}}, x0 || x1});
        chk("fb_wr_en", {{(DATA-1){1'b0}}, fb_wr_en}, {{(DATA-1){1'b0}}, x0 || x1});
      end
      if (x0 || x1) begin
        xs = x1;
        if (s0_valid && s1_valid) chk("rr_winner", {{(DATA-1){1'b0}}, xs}, {{(DATA-1){1'b0}}, !ref_rr});
        p.src = xs;
        p.a   = xs ? s1_op_a : s0_op_a;
        p.b   = xs ? s1_op_b : s0_op_b;
        chk("fa_din", fa_din, p.a);
        chk("fb_din", fb_din, p.b);
        ref_q.push_back(p);
        ref_rr = xs;
        n_acc++;
      end
      if (mul_start) begin
        if (ref_q.size() == 0) fail_now("mul_start", "start with no accepted pair outstanding");
        else begin
          p = ref_q.pop_front();
          chk("mul_op_a", mul_op_a, p.a);
          chk("mul_op_b", mul_op_b, p.b);
          infl_q.push_back(p.src);
        end
        n_start++;
      end
      if (res_valid) begin
        if (infl_q.size() == 0) fail_now("res_valid", "pulse with no op in flight");
        else chk("res_src", {{(DATA-1){1'b0}}, res_src}, {{(DATA-1){1'b0}}, infl_q.pop_front()});
        n_res++;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd(output logic [DATA-1:0] v);
    for (int i = 0; i < DATA / 32; i++) v[i*32 +: 32] = $urandom;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0; s0_valid = 1'b0; s1_valid = 1'b0; fifo_flush = 1'b1; mul_hold = 1'b0;
    tick();
    tick();
    rst_n = 1'b1; fifo_flush = 1'b0;
  endtask

  task automatic drain(input string nm, input int budget);
    int n;
    n = 0;
    while (n < budget && !(ref_q.size() == 0 && infl_q.size() == 0 && pairs == 4'd0 && !mul_pend)) begin
      tick();
      n++;
    end
    chk(nm, DATA'(n < budget), DATA'(1));
  endtask

  // Push cnt pairs from s0 with fresh random operands, one per accepted cycle.
  task automatic push_s0(input int cnt);
    int got, g;
    got = 0; g = 0;
    rnd(s0_op_a); rnd(s0_op_b);
    s0_valid = 1'b1;
    while (got < cnt && g < 40) begin
      @(negedge clk);
      if (s0_ready) got++;
      tick();
      g++;
      rnd(s0_op_a); rnd(s0_op_b);
    end
    s0_valid = 1'b0;
    chk("push_s0_count", DATA'(got), DATA'(cnt));
  endtask

  typedef struct {
    bit              v0, v1;
    logic [DATA-1:0] a0, b0, a1, b1;
    int              lat;
    bit              exp_src;
    logic [DATA-1:0] exp_a, exp_b;
  } vec_t;

  function automatic vec_t mk(input bit v0, input bit v1,
                              input logic [DATA-1:0] a0, input logic [DATA-1:0] b0,
                              input logic [DATA-1:0] a1, input logic [DATA-1:0] b1,
                              input int lat, input bit src,
                              input logic [DATA-1:0] ea, input logic [DATA-1:0] eb);
    vec_t v;
    v.v0 = v0; v.v1 = v1; v.a0 = a0; v.b0 = b0; v.a1 = a1; v.b1 = b1;
    v.lat = lat; v.exp_src = src; v.exp_a = ea; v.exp_b = eb;
    return v;
  endfunction

  // ---------------- main sequence ----------------
  initial begin : main
    vec_t            vt[7];
    vec_t            v;
    logic [DATA-1:0] ones, fives;
    int              n, pop_at, start_at, res_at, first_src, g_cnt, r0, s0c, a0, src, got;
    bit              x0, x1;

    ones  = {DATA{1'b1}};
    fives = {(DATA/4){4'h5}};
    // After reset rr_last = 1, so the first tie goes to s0; winners then alternate on ties.
    vt[0] = mk(1, 0, DATA'(3),  DATA'(5),  '0,         '0,          10, 0, DATA'(3),  DATA'(5));
    vt[1] = mk(1, 1, DATA'(7),  DATA'(9),  DATA'(11),  DATA'(13),   2,  1, DATA'(11), DATA'(13));
    vt[2] = mk(1, 1, DATA'(21), DATA'(22), DATA'(23),  DATA'(24),   4,  0, DATA'(21), DATA'(22));
    vt[3] = mk(0, 1, '0,        '0,        DATA'(100), DATA'(200),  3,  1, DATA'(100), DATA'(200));
    vt[4] = mk(1, 0, ones,      '0,        '0,         '0,          2,  0, ones,      '0);
    vt[5] = mk(1, 1, DATA'(1),  DATA'(2),  ones,       fives,       5,  1, ones,      fives);
    vt[6] = mk(1, 1, DATA'(55), DATA'(66), DATA'(77),  DATA'(88),   2,  0, DATA'(55), DATA'(66));

    rst_n = 1'b0; s0_valid = 1'b0; s1_valid = 1'b0;
    s0_op_a = '0; s0_op_b = '0; s1_op_a = '0; s1_op_b = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    chk("rst_pairs",     DATA'(pairs),     '0);
    chk("rst_desync",    DATA'(desync),    '0);
    chk("rst_mul_start", DATA'(mul_start), '0);
    chk("rst_fa_rd_en",  DATA'(fa_rd_en),  '0);
    chk("rst_fb_rd_en",  DATA'(fb_rd_en),  '0);
    chk("rst_res_valid", DATA'(res_valid), '0);
    chk("rst_fa_wr_en",  DATA'(fa_wr_en),  '0);
    chk("rst_mul_op_a",  mul_op_a,         '0);
    chk("rst_mul_op_b",  mul_op_b,         '0);

    // Table: one op at a time, exact pop/start/result timing.
    for (int i = 0; i < 7; i++) begin
      v = vt[i];
      mul_lat = v.lat;
      s0_valid = v.v0; s0_op_a = v.a0; s0_op_b = v.b0;
      s1_valid = v.v1; s1_op_a = v.a1; s1_op_b = v.b1;
      @(negedge clk);
      chk($sformatf("vec%0d_win_ready", i), DATA'(v.exp_src ? s1_ready : s0_ready), DATA'(1));
      if (v.v0 && v.v1) chk($sformatf("vec%0d_lose_ready", i), DATA'(v.exp_src ? s0_ready : s1_ready), '0);
      chk($sformatf("vec%0d_fa_din", i), fa_din, v.exp_a);
      chk($sformatf("vec%0d_fb_din", i), fb_din, v.exp_b);
      tick();
      s0_valid = 1'b0; s1_valid = 1'b0;
      chk($sformatf("vec%0d_pairs1", i), DATA'(pairs), DATA'(1));
      pop_at = -1; start_at = -1; n = 0;
      while (start_at < 0 && n < 12) begin
        tick();
        n++;
        if (fa_rd_en && pop_at < 0) pop_at = n;
        if (mul_start) start_at = n;
      end
      chk($sformatf("vec%0d_pop_at", i), DATA'(pop_at), DATA'(1));
      chk($sformatf("vec%0d_start_at", i), DATA'(start_at), DATA'(3));
      chk($sformatf("vec%0d_op_a", i), mul_op_a, v.exp_a);
      chk($sformatf("vec%0d_op_b", i), mul_op_b, v.exp_b);
      res_at = -1; n = 0;
      while (res_at < 0 && n < 40) begin
        tick();
        n++;
        if (res_valid) begin
          res_at = n;
          chk($sformatf("vec%0d_res_src", i), DATA'(res_src), DATA'(v.exp_src));
        end
      end
      chk($sformatf("vec%0d_res_at", i), DATA'(res_at), DATA'(v.lat));
      tick();
      chk($sformatf("vec%0d_res_pulse", i), DATA'(res_valid), '0);
      chk($sformatf("vec%0d_pairs0", i), DATA'(pairs), '0);
    end

    // Fairness: both requesters valid continuously, random operands.
    do_reset();
    mul_lat = 2; first_src = -1; g_cnt = 0; a0 = n_acc; r0 = n_res;
    rnd(s0_op_a); rnd(s0_op_b); rnd(s1_op_a); rnd(s1_op_b);
    s0_valid = 1'b1; s1_valid = 1'b1;
    repeat (40) begin
      @(negedge clk);
      x0 = s0_ready; x1 = s1_ready;
      if ((x0 || x1) && first_src < 0) first_src = x1 ? 1 : 0;
      if (x0 || x1) g_cnt++;
      tick();
      if (x0) begin rnd(s0_op_a); rnd(s0_op_b); end
      if (x1) begin rnd(s1_op_a); rnd(s1_op_b); end
    end
    s0_valid = 1'b0; s1_valid = 1'b0;
    chk("fair_first_grant", DATA'(first_src), '0);
    chk("fair_progress", DATA'(g_cnt >= 10), DATA'(1));
    drain("fair_drain", 600);
    chk("fair_all_results", DATA'(n_res - r0), DATA'(n_acc - a0));
    chk("fair_desync", DATA'(desync), '0);

    // Full: multiplier stalled, first pair issued, 8 more buffered, then exactly one more after done.
    do_reset();
    mul_hold = 1'b1; mul_lat = 2; a0 = n_acc;
    rnd(s0_op_a); rnd(s0_op_b);
    s0_valid = 1'b1;
    repeat (30) begin
      @(negedge clk);
      x0 = s0_ready;
      tick();
      if (x0) begin rnd(s0_op_a); rnd(s0_op_b); end
    end
    chk("full_accepts", DATA'(n_acc - a0), DATA'(9));
    chk("full_pairs", DATA'(pairs), DATA'(8));
    @(negedge clk);
    chk("full_ready_low", DATA'(s0_ready), '0);
    tick();
    mul_lat = 40; mul_hold = 1'b0; a0 = n_acc;
    repeat (12) begin
      @(negedge clk);
      x0 = s0_ready;
      tick();
      if (x0) begin rnd(s0_op_a); rnd(s0_op_b); end
    end
    s0_valid = 1'b0;
    chk("full_one_more", DATA'(n_acc - a0), DATA'(1));
    chk("full_pairs_again", DATA'(pairs), DATA'(8));
    mul_lat = 2;
    drain("full_drain", 800);

    // Accept in the POP cycle: count holds at 2, tag order intact.
    do_reset();
    mul_hold = 1'b1; mul_lat = 2; r0 = n_res;
    push_s0(3);
    repeat (6) tick();
    chk("sim_pairs_before", DATA'(pairs), DATA'(2));
    mul_hold = 1'b0; n = 0;
    while (!fa_rd_en && n < 20) begin tick(); n++; end
    chk("sim_pop_seen", DATA'(fa_rd_en), DATA'(1));
    rnd(s1_op_a); rnd(s1_op_b);
    s1_valid = 1'b1;
    @(negedge clk);
    chk("sim_s1_ready", DATA'(s1_ready), DATA'(1));
    chk("sim_pairs_pop", DATA'(pairs), DATA'(2));
    tick();
    s1_valid = 1'b0;
    chk("sim_pairs_after", DATA'(pairs), DATA'(2));
    drain("sim_drain", 300);
    chk("sim_results", DATA'(n_res - r0), DATA'(4));

    // Wrap: 20 ops alternating sources, order checked by the scoreboard across pointer wrap.
    do_reset();
    mul_lat = 3; r0 = n_res; s0c = n_start;
    for (int i = 0; i < 20; i++) begin
      src = i % 2;
      if (src == 1) begin rnd(s1_op_a); rnd(s1_op_b); s1_valid = 1'b1; end
      else begin rnd(s0_op_a); rnd(s0_op_b); s0_valid = 1'b1; end
      got = 0; n = 0;
      while (got == 0 && n < 200) begin
        @(negedge clk);
        got = (src == 1) ? int'(s1_ready) : int'(s0_ready);
        tick();
        n++;
      end
      s0_valid = 1'b0; s1_valid = 1'b0;
      if (got == 0) fail_now($sformatf("wrap_accept%0d", i), "no ready within 200 cycles");
    end
    drain("wrap_drain", 400);
    chk("wrap_starts", DATA'(n_start - s0c), DATA'(20));
    chk("wrap_results", DATA'(n_res - r0), DATA'(20));

    // Reset while BUSY: abandoned op produces no result; stale FIFO entries raise desync.
    do_reset();
    mul_hold = 1'b1; mul_lat = 2;
    push_s0(4);
    repeat (6) tick();
    chk("rb_pairs_before", DATA'(pairs), DATA'(3));
    r0 = n_res;
    rst_n = 1'b0; mul_hold = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rb_pairs_reset", DATA'(pairs), '0);
    chk("rb_desync_in_reset", DATA'(desync), '0);
    chk("rb_mul_op_a", mul_op_a, '0);
    tick();
    chk("rb_desync_set", DATA'(desync), DATA'(1));
    repeat (10) tick();
    chk("rb_desync_sticky", DATA'(desync), DATA'(1));
    chk("rb_no_result", DATA'(n_res - r0), '0);
    chk("rb_no_pop", DATA'(pairs), '0);

    do_reset();
    tick();
    chk("desync_cleared", DATA'(desync), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
